// File: rtl/phaser_pkg.sv
// Shared encodings for the Phaser control path: command modes, FSM states and the
// default phase width / period length.
package phaser_pkg;

    localparam int DEF_PHASE_W = 4;
    localparam int PERIOD      = 2 ** DEF_PHASE_W;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DN   = 2'b10,
        MODE_STOP = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PEND  = 2'b01,
        ST_SWEEP = 2'b10
    } state_e;

endpackage

// File: rtl/phase_period_counter.sv
// Free-running Phaser period tracker: per_cnt, the last-cycle-of-period flag, and a
// registered pulse on the first cycle of every period except the one right after reset.
module phase_period_counter
    import phaser_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PHASE_W-1:0] per_cnt,
    output logic               boundary,
    output logic               period_start
);

    logic [PHASE_W-1:0] per_cnt_q;
    logic [PHASE_W-1:0] per_cnt_d;
    logic               period_start_q;
    logic               period_start_d;

    always_comb begin
        per_cnt_d      = per_cnt_q + PHASE_W'(1);
        // Registered from the wrap so it lines up with per_cnt == 0.
        period_start_d = (per_cnt_q == {PHASE_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            per_cnt_q      <= per_cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign per_cnt      = per_cnt_q;
    assign boundary     = (per_cnt_q == {PHASE_W{1'b1}});
    assign period_start = period_start_q;

endmodule

// File: rtl/phase_steer_ctrl.sv
// Phaser compare-word controller: takes (base, step) commands, holds them until the next
// period boundary, and optionally sweeps the element step every SWEEP_DIV periods.
module phase_steer_ctrl
    import phaser_pkg::*;
#(
    parameter int PHASE_W   = DEF_PHASE_W,
    parameter int SWEEP_DIV = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [PHASE_W-1:0] cmd_base,
    input  logic [PHASE_W-1:0] cmd_step,
    output logic [PHASE_W-1:0] comp1,
    output logic [PHASE_W-1:0] comp2,
    output logic               busy,
    output logic               period_start
);

    localparam int               SC_W    = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SWEEP_DIV - 1);

    // Handshake: a command transfers on any rising edge where cmd_valid and cmd_ready are
    // both high; cmd_ready depends only on state, never on cmd_valid.
    logic               accept;
    logic               boundary;
    logic [PHASE_W-1:0] per_cnt;
    mode_e              cmd_mode_e;

    state_e             state_q,     state_d;
    mode_e              sh_mode_q,   sh_mode_d;
    logic [PHASE_W-1:0] sh_base_q,   sh_base_d;
    logic [PHASE_W-1:0] sh_step_q,   sh_step_d;
    logic [PHASE_W-1:0] comp1_q,     comp1_d;
    logic [PHASE_W-1:0] comp2_q,     comp2_d;
    logic [PHASE_W-1:0] step_q,      step_d;
    logic [SC_W-1:0]    sweep_cnt_q, sweep_cnt_d;

    phase_period_counter #(.PHASE_W(PHASE_W)) u_period (
        .clk          (clk),
        .rst          (rst),
        .per_cnt      (per_cnt),
        .boundary     (boundary),
        .period_start (period_start)
    );

    assign cmd_mode_e = mode_e'(cmd_mode);
    assign accept     = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sh_mode_q   <= MODE_LOAD;
            sh_base_q   <= '0;
            sh_step_q   <= '0;
            comp1_q     <= '0;
            comp2_q     <= '0;
            step_q      <= '0;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sh_mode_q   <= sh_mode_d;
            sh_base_q   <= sh_base_d;
            sh_step_q   <= sh_step_d;
            comp1_q     <= comp1_d;
            comp2_q     <= comp2_d;
            step_q      <= step_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_mode_d   = sh_mode_q;
        sh_base_d   = sh_base_q;
        sh_step_d   = sh_step_q;
        comp1_d     = comp1_q;
        comp2_d     = comp2_q;
        step_d      = step_q;
        sweep_cnt_d = sweep_cnt_q;

        // A newly accepted command pre-empts any sweep update on the same edge.
        if (accept) begin
            if (cmd_mode_e == MODE_STOP) begin
                state_d     = ST_IDLE;
                sweep_cnt_d = '0;
            end else begin
                state_d   = ST_PEND;
                sh_mode_d = cmd_mode_e;
                sh_base_d = cmd_base;
                sh_step_d = cmd_step;
            end
        end else begin
            unique case (state_q)
                ST_PEND: begin
                    if (boundary) begin
                        comp1_d     = sh_base_q;
                        comp2_d     = sh_base_q + sh_step_q;
                        step_d      = sh_step_q;
                        sweep_cnt_d = '0;
                        state_d     = (sh_mode_q == MODE_LOAD) ? ST_IDLE : ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (boundary) begin
                        if (sweep_cnt_q == SC_LAST) begin
                            step_d      = (sh_mode_q == MODE_DN) ? step_q - PHASE_W'(1)
                                                                 : step_q + PHASE_W'(1);
                            comp2_d     = comp1_q + step_d;
                            sweep_cnt_d = '0;
                        end else begin
                            sweep_cnt_d = sweep_cnt_q + SC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready = (state_q != ST_PEND);
        busy      = (state_q != ST_IDLE);
    end

    assign comp1 = comp1_q;
    assign comp2 = comp2_q;

endmodule
